// File: rtl/adder32_seq_ctrl_if.sv
// Operand/result handshake bundle for the byte-serial 32-bit adder.
// Master drives operands and takes results; slave is the sequencer.
interface adder32_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder32_seq_ctrl.sv
// 32-bit add/sub over four cycles through one 8-bit lookahead slice.
// Subtract support is enabled by defining ADDER32_SEQ_SUB_EN.
module all_gates_a (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       car,
  output logic [7:0] s
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_c[0] = car;
    for (int i = 0; i < 8; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign s = w_p ^ w_c[7:0];
endmodule

module adder32_seq_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  adder32_seq_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_in_ready;
  logic        w_out_valid;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_sum;
  logic [1:0]  r_idx;
  logic        r_c;
  logic        r_cout;
  logic        r_ovf;

  logic        w_sub;
  logic [31:0] w_b_in;
  logic [7:0]  w_sa;
  logic [7:0]  w_sb;
  logic [7:0]  w_s;
  logic        w_cnext;
  logic        w_ovf;

`ifdef ADDER32_SEQ_SUB_EN
  assign w_sub  = bus.op_sub;
  assign w_b_in = bus.op_sub ? ~bus.b : bus.b;
`else
  logic w_unused_sub;
  assign w_unused_sub = bus.op_sub;
  assign w_sub        = 1'b0;
  assign w_b_in       = bus.b;
`endif

  assign w_sa = r_a[{r_idx, 3'b000} +: 8];
  assign w_sb = r_b[{r_idx, 3'b000} +: 8];

  all_gates_a u_slice (
    .a   (w_sa),
    .b   (w_sb),
    .car (r_c),
    .s   (w_s)
  );

  // Slice has no carry-out; recover it from the MSBs.
  assign w_cnext = (w_sa[7] & w_sb[7])
                 | ((w_sa[7] ^ w_sb[7]) & ~w_s[7]);
  assign w_ovf   = (r_a[31] == r_b[31]) & (w_s[7] != r_a[31]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC: begin
        if (r_idx == 2'd3) w_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_idx  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= w_b_in;
      r_c   <= w_sub;
      r_idx <= '0;
    end else if (r_state == S_CALC) begin
      r_sum[{r_idx, 3'b000} +: 8] <= w_s;
      r_c   <= w_cnext;
      r_idx <= r_idx + 2'd1;
      // Flags are latched with the top byte so DONE holds them steady.
      if (r_idx == 2'd3) begin
        r_cout <= w_cnext;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_adder32_seq_ctrl.sv
// Directed bench for the byte-serial 32-bit adder sequencer.
// Expected values are hand-computed per build configuration.
module tb_adder32_seq_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  adder32_seq_ctrl_if bus ();

  adder32_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic sub,
                        input logic [31:0] e_sum,
                        input logic e_c,
                        input logic e_v,
                        input bit take);
    int n;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op_sub   = sub;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'hCAFE_F00D;
    bus.op_sub   = ~sub;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.out_valid && n < 20);
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_sum"}, bus.sum, e_sum);
    chk({tag, "_cv"}, {30'd0, bus.cout, bus.ovf}, {30'd0, e_c, e_v});
    if (take) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_xfer"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    chk("rst_sum", bus.sum, 32'd0);
    chk("rst_cv", {30'd0, bus.cout, bus.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ff", 32'h0000_00FF, 32'h1, 1'b0,
           32'h0000_0100, 1'b0, 1'b0, 1'b1);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0,
           32'h0, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0,
           32'h8000_0000, 1'b0, 1'b1, 1'b1);
`ifdef ADDER32_SEQ_SUB_EN
    run_op("sub_neg", 32'd5, 32'd7, 1'b1,
           32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    run_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b1,
           32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
`else
    run_op("sub_neg", 32'd5, 32'd7, 1'b1,
           32'd12, 1'b0, 1'b0, 1'b1);
    run_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b1,
           32'h8000_0001, 1'b0, 1'b0, 1'b1);
`endif

    run_op("bp", 32'h1234_5678, 32'h1111_1111, 1'b0,
           32'h2345_6789, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk);
      #1;
      chk("bp_sum", bus.sum, 32'h2345_6789);
      chk("bp_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_xfer", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 32'hAAAA_AAAA;
    bus.b        = 32'h5555_5555;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    chk("ar_sum", bus.sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 32'd3, 32'd4, 1'b0,
           32'd7, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
